// File: rtl/saber_polmul_pkg.sv
// rtl/saber_polmul_pkg.sv - shared constants, state type and latency for the polmul result writer
//
// Purpose : constants of the 256-coefficient Saber polynomial multiplier datapath as seen
//           by its result writer, the writer FSM state type and the write-path latency.
// Config  : POLMUL_WRITER_ROUND_EN selects the in-flight 13->10 bit rounding stage (LAT=2).
package saber_polmul_pkg;

   localparam int NUM_WORDS = 64;   // 256 coefficients, four per 64-bit word
   localparam int COEF_W    = 13;   // coefficient width in 13-bit mode
   localparam int LANE_W    = 16;   // lane width on the 64-bit port
   localparam int WORD_W    = 4 * LANE_W;
   localparam int EQ        = 13;
   localparam int EP        = 10;
   localparam int H1        = 4;    // rounding constant added before the shift
   localparam int SHIFT     = EQ - EP;

`ifdef POLMUL_WRITER_ROUND_EN
   localparam int LAT = 2;          // capture/round register + write register
`else
   localparam int LAT = 1;          // write register doubles as capture register
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } writer_state_t;

endpackage

// File: rtl/polmul_result_writer_if.sv
// rtl/polmul_result_writer_if.sv - multiplier-side and BRAM-side signals of the result writer
//
// Purpose : bundles the control inputs, the multiplier read-shift handshake and the result
//           BRAM write bus of polmul_result_writer.
// Ports   : start, mode16, base_addr, coeff4x_in      - driven by the environment
//           read_o, wr_en, wr_addr, wr_data, busy, done - driven by the writer
// Modports: master = the writer, slave = multiplier/BRAM/controller side.
interface polmul_result_writer_if #(
   parameter int ADDR_W = 8
);

   logic              start;
   logic              mode16;
   logic [ADDR_W-1:0] base_addr;
   logic [63:0]       coeff4x_in;
   logic              read_o;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [63:0]       wr_data;
   logic              busy;
   logic              done;

   modport master (
      input  start, mode16, base_addr, coeff4x_in,
      output read_o, wr_en, wr_addr, wr_data, busy, done
   );

   modport slave (
      output start, mode16, base_addr, coeff4x_in,
      input  read_o, wr_en, wr_addr, wr_data, busy, done
   );

endinterface

// File: rtl/polmul_result_writer_round4.sv
// rtl/polmul_result_writer_round4.sv - coeff_round4: registered four-lane Saber rounding
//
// Purpose : per 16-bit lane computes ((lane[12:0] + H_CONST) mod 2^COEF_W) >> SHIFT,
//           zero-extended; in mode16 the word passes through unchanged. Always one
//           register stage so latency does not depend on mode16. Valid and address
//           travel alongside the data.
// Ports   : clk, rst (sync, active-high)
//           mode16_i, vld_i, addr_i, data_i - captured word from the multiplier port
//           vld_o, addr_o, data_o           - registered rounded word
// Config  : instantiated only when POLMUL_WRITER_ROUND_EN is defined.
module coeff_round4 #(
   parameter int ADDR_W  = 8,
   parameter int LANE_W  = 16,
   parameter int COEF_W  = 13,
   parameter int H_CONST = 4,
   parameter int SHIFT   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode16_i,
   input  logic                vld_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [4*LANE_W-1:0] data_i,
   output logic                vld_o,
   output logic [ADDR_W-1:0]   addr_o,
   output logic [4*LANE_W-1:0] data_o
);

   logic [4*LANE_W-1:0] rnd;

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [COEF_W-1:0] sum;
      // Sum is kept at COEF_W bits so the carry out of 0x1FFF+H wraps, as in the reference.
      assign sum = data_i[l*LANE_W +: COEF_W] + COEF_W'(H_CONST);
      assign rnd[l*LANE_W +: LANE_W] = LANE_W'(sum >> SHIFT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_o  <= 1'b0;
         addr_o <= '0;
         data_o <= '0;
      end else begin
         vld_o  <= vld_i;
         addr_o <= addr_i;
         data_o <= mode16_i ? data_i : rnd;
      end
   end

endmodule

// File: rtl/polmul_result_writer.sv
// rtl/polmul_result_writer.sv - drains the polmul accumulator into the result BRAM
//
// Purpose : on start, asserts read_o for NUM_WORDS consecutive cycles, capturing the
//           multiplier's 64-bit four-coefficient port each cycle (the multiplier shifts on
//           the following edge), and writes every word to base_addr + index (mod 2^ADDR_W).
// Ports   : clk, rst (sync, active-high)
//           bus (master): start, mode16, base_addr, coeff4x_in in;
//                         read_o, wr_en, wr_addr, wr_data, busy, done out
// Config  : POLMUL_WRITER_ROUND_EN adds coeff_round4 (13->10 bit rounding when mode16=0)
//           and one cycle of latency; undefined, words are written unchanged.
module polmul_result_writer #(
   parameter int NUM_WORDS = saber_polmul_pkg::NUM_WORDS,
   parameter int ADDR_W    = 8
`ifdef POLMUL_WRITER_ROUND_EN
   ,
   parameter int COEF_W    = saber_polmul_pkg::COEF_W,
   parameter int H_CONST   = saber_polmul_pkg::H1,
   parameter int SHIFT     = saber_polmul_pkg::SHIFT
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   polmul_result_writer_if.master bus
);
   import saber_polmul_pkg::*;

   localparam int CNT_W = $clog2(NUM_WORDS);

   writer_state_t     state_q;
   logic [CNT_W-1:0]  word_cnt_q;
   logic [1:0]        flush_cnt_q;
   logic [ADDR_W-1:0] base_q;
   logic              read_q;
   logic              busy_q;
   logic              done_q;

   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [63:0]       wr_data_q;

   // Address of the word presented on coeff4x_in this cycle.
   logic [ADDR_W-1:0] cur_addr;
   assign cur_addr = base_q + ADDR_W'(word_cnt_q);

   logic              stg_vld;
   logic [ADDR_W-1:0] stg_addr;
   logic [63:0]       stg_data;

`ifdef POLMUL_WRITER_ROUND_EN
   coeff_round4 #(
      .ADDR_W  (ADDR_W),
      .LANE_W  (LANE_W),
      .COEF_W  (COEF_W),
      .H_CONST (H_CONST),
      .SHIFT   (SHIFT)
   ) u_round (
      .clk      (clk),
      .rst      (rst),
      .mode16_i (bus.mode16),
      .vld_i    (read_q),
      .addr_i   (cur_addr),
      .data_i   (bus.coeff4x_in),
      .vld_o    (stg_vld),
      .addr_o   (stg_addr),
      .data_o   (stg_data)
   );
`else
   // Without rounding the write register itself captures the port.
   assign stg_vld  = read_q;
   assign stg_addr = cur_addr;
   assign stg_data = bus.coeff4x_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= '0;
         flush_cnt_q <= '0;
         base_q      <= '0;
         read_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  base_q     <= bus.base_addr;
                  word_cnt_q <= '0;
                  read_q     <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= DRAIN;
               end
            end
            DRAIN: begin
               word_cnt_q <= word_cnt_q + 1'b1;
               if (read_q && word_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                  read_q      <= 1'b0;
                  flush_cnt_q <= '0;
                  state_q     <= FLUSH;
               end
            end
            FLUSH: begin
               // LAT cycles retire the words still in the capture/write registers.
               if (flush_cnt_q == 2'(LAT - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  flush_cnt_q <= flush_cnt_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= stg_vld;
         if (stg_vld) begin
            wr_addr_q <= stg_addr;
            wr_data_q <= stg_data;
         end
      end
   end

   assign bus.read_o  = read_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: doc/polmul_result_writer.md
Name: polmul_result_writer

Overview:
- Downstream stage of the 256-coefficient polynomial multiplier.
- Once multiplication finishes, this block drains the multiplier's 3328-bit accumulator through its 64-bit four-coefficient output port, using the multiplier's read-shift input.
- It packs each word and writes it sequentially into a result BRAM at a caller-supplied base address.
- It optionally applies Saber rounding (13-bit to 10-bit) in flight.

Parameters:
- NUM_WORDS, 64, number of 64-bit words drained (256 coeffs / 4 per word).
- ADDR_W, 8, result BRAM address width.
- COEF_W, 13, coefficient width in 13-bit mode.
- H_CONST, 4, rounding constant added before the shift (ROUND_EN only).
- SHIFT, 3, right shift applied by rounding (eq - ep) (ROUND_EN only).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse; begins a drain (tie to rising edge of multiplier done).
- mode16, input, 1, 1 = multiplier is in 4x16-bit coefficient mode; held stable during a drain.
- base_addr, input, ADDR_W, first write address; sampled on accepted start.
- coeff4x_in, input, 64, multiplier coefficient output; combinational from its accumulator.
- read_o, output, 1, shift-accumulator request to the multiplier.
- wr_en, output, 1, BRAM write enable.
- wr_addr, output, ADDR_W, BRAM write address.
- wr_data, output, 64, BRAM write data; four 16-bit lanes, lane 0 = bits 15:0.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse after the last write.

Behaviour:
- Reset: clk/rst as decided (synchronous, active-high). All outputs return to 0: read_o, wr_en, wr_addr, wr_data, busy, done. FSM goes to IDLE; counters are cleared.
- States:
  - IDLE -> DRAIN on start.
  - DRAIN -> FLUSH when word_cnt == NUM_WORDS-1 and read_o is high.
  - FLUSH -> DONE when the pipeline is empty.
  - DONE -> IDLE after one cycle.
- Start rules:
  - start is ignored in any state other than IDLE.
  - start in DONE is also ignored.
- DRAIN:
  - read_o=1 every cycle, exactly NUM_WORDS consecutive cycles.
  - coeff4x_in is captured in the same cycle read_o is high, because the multiplier shifts on the following edge.
  - word_cnt increments on each capture.
- Pipeline:
  - Capture register feeds the write stage.
  - wr_en/wr_addr/wr_data are registered.
  - Latency from read_o high to the matching wr_en is LAT cycles: LAT = 1 without ROUND_EN, 2 with it.
- Addressing:
  - wr_addr = base_addr + word index, modulo 2^ADDR_W.
  - Wrap-around is legal and silent.
- Lane handling (no rounding):
  - wr_data = coeff4x_in unchanged. Lanes already carry zero-extended 13-bit or 10-bit values.
- FLUSH: lasts exactly LAT cycles, read_o=0, remaining writes retire.
- Done/busy:
  - done pulses in the DONE cycle, i.e. the cycle after the last wr_en.
  - busy=1 from the cycle after the accepted start through DONE, inclusive.
- Totals: exactly NUM_WORDS write pulses per drain; no duplicates; addresses strictly consecutive.
- rst mid-drain: immediate return to IDLE. No further wr_en; pending pipeline data is discarded. The multiplier accumulator state is the caller's responsibility.
- start coincident with rst: rst wins.

Optional Feature:
- Macro POLMUL_WRITER_ROUND_EN.
- Defined:
  - Adds a registered rounding stage (LAT=2).
  - In mode16=0, each lane becomes ((lane[12:0] + H_CONST) mod 2^COEF_W) >> SHIFT, zero-extended to 16 bits.
  - In mode16=1, lanes pass through unchanged, but the extra cycle is kept so latency stays uniform.
- Undefined: no rounding logic; LAT=1.

Decomposition:
- Package saber_polmul_pkg: NUM_WORDS, COEF_W=13, LANE_W=16, EQ=13, EP=10, H1=4, and the writer state enum (IDLE, DRAIN, FLUSH, DONE).
- One natural sub-module: coeff_round4 (four-lane add-and-shift, registered), instantiated only under the macro.

Test Plan:
- Reset, then start with base_addr=0x10, lanes counting 0,1,2,…: read_o high exactly 64 cycles; 64 writes to 0x10..0x4F; word k = lanes {4k+3,4k+2,4k+1,4k}; done one cycle after the last write.
- base_addr=0xF0: addresses 0xF0..0xFF then 0x00..0x2F; no gaps.
- start re-pulsed during DRAIN and during DONE: ignored; still exactly 64 writes, single done.
- rst asserted at word 20: wr_en low from the next cycle; busy=0; a new start restarts cleanly at base_addr with 64 writes.
- ROUND_EN, mode16=0, lanes {0x1FFF, 0x0004, 0x0003, 0x1000}: wr_data lanes {0x0000, 0x0001, 0x0000, 0x0200}; first wr_en 2 cycles after the first read_o.
- ROUND_EN, mode16=1, lane 0x03FF: passes through as 0x03FF; latency still 2.
